// File: rtl/leglite_single_system.sv
// Single-cycle 16-bit LEGLite system: CPU core, instruction ROM, data RAM and
// memory-mapped switches/display in one block, with internal buses exported for debug.
module leglite_single_system (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [6:0]  io_display,
    output logic [15:0] iaddr,
    output logic [15:0] idata,
    output logic [15:0] draddr,
    output logic [15:0] dwdata,
    output logic [15:0] drdata,
    output logic        dwrite,
    output logic        dread,
    output logic [15:0] alu_out
);

    typedef enum logic [3:0] {
        OP_R    = 4'd0,
        OP_ADDI = 4'd1,
        OP_ANDI = 4'd2,
        OP_LD   = 4'd3,
        OP_ST   = 4'd4,
        OP_CBZ  = 4'd5,
        OP_B    = 4'd6
    } opcode_e;

    localparam logic [15:0] NOP_WORD = 16'hF000;

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [6:0]  display_q;
    logic [15:0] regs_q [0:7];
    logic [15:0] ram_q  [0:31];

    logic [15:0] romWord;
    logic [15:0] instr;
    opcode_e     op;
    logic [15:0] immSext;
    logic [15:0] off9Bytes;
    logic [15:0] off12Bytes;
    logic [15:0] rmVal;
    logic [15:0] rnRVal;
    logic [15:0] rnIVal;
    logic [15:0] rtVal;
    logic [15:0] aluOut;
    logic [15:0] storeData;
    logic [15:0] rdData;
    logic [15:0] wrData;
    logic [2:0]  wrIdx;
    logic        regWe;
    logic        isLoad;
    logic        dWr;
    logic        ramSel;
    logic        dispSel;
    logic        sw0Sel;
    logic        sw1Sel;

    // Default lab program; anything beyond the 64-word window fetches a NOP.
    always_comb begin
        romWord = NOP_WORD;
        if (pc_q[15:7] == 9'd0) begin
            case (pc_q[6:1])
                6'd0:    romWord = 16'h1039;
                6'd1:    romWord = 16'h3E3A;
                6'd2:    romWord = 16'h5012;
                6'd3:    romWord = 16'h1049;
                6'd4:    romWord = 16'h4C39;
                6'd5:    romWord = 16'h6FFC;
                default: romWord = NOP_WORD;
            endcase
        end
    end

    assign instr      = romWord;
    assign op         = opcode_e'(instr[15:12]);
    assign immSext    = {{10{instr[11]}}, instr[11:6]};
    assign off9Bytes  = {{6{instr[11]}}, instr[11:3], 1'b0};
    assign off12Bytes = {{3{instr[11]}}, instr[11:0], 1'b0};

    // X7 is the hardwired zero register on every read port.
    assign rmVal  = (instr[11:9] == 3'd7) ? 16'd0 : regs_q[instr[11:9]];
    assign rnRVal = (instr[8:6]  == 3'd7) ? 16'd0 : regs_q[instr[8:6]];
    assign rnIVal = (instr[5:3]  == 3'd7) ? 16'd0 : regs_q[instr[5:3]];
    assign rtVal  = (instr[2:0]  == 3'd7) ? 16'd0 : regs_q[instr[2:0]];

    always_comb begin
        aluOut    = 16'd0;
        regWe     = 1'b0;
        wrIdx     = 3'd0;
        isLoad    = 1'b0;
        dWr       = 1'b0;
        storeData = 16'd0;
        pc_d      = pc_q + 16'd2;
        case (op)
            OP_R: begin
                wrIdx = instr[5:3];
                case (instr[2:0])
                    3'd0: begin aluOut = rnRVal + rmVal; regWe = 1'b1; end
                    3'd1: begin aluOut = rnRVal - rmVal; regWe = 1'b1; end
                    3'd2: begin aluOut = rnRVal & rmVal; regWe = 1'b1; end
                    3'd3: begin aluOut = rnRVal | rmVal; regWe = 1'b1; end
                    default: aluOut = 16'd0;
                endcase
            end
            OP_ADDI: begin
                aluOut = rnIVal + immSext;
                regWe  = 1'b1;
                wrIdx  = instr[2:0];
            end
            OP_ANDI: begin
                aluOut = rnIVal & immSext;
                regWe  = 1'b1;
                wrIdx  = instr[2:0];
            end
            OP_LD: begin
                aluOut = rnIVal + immSext;
                regWe  = 1'b1;
                wrIdx  = instr[2:0];
                isLoad = 1'b1;
            end
            OP_ST: begin
                aluOut    = rnIVal + immSext;
                dWr       = 1'b1;
                storeData = rtVal;
            end
            OP_CBZ: begin
                aluOut = rtVal;
                if (rtVal == 16'd0) begin
                    pc_d = pc_q + off9Bytes;
                end
            end
            OP_B: begin
                pc_d = pc_q + off12Bytes;
            end
            default: aluOut = 16'd0;
        endcase
    end

    // Address bit 0 is ignored, so I/O decode compares the word address only.
    assign ramSel  = (aluOut[15:6] == 10'd0);
    assign dispSel = (aluOut[15:1] == 15'h7FF8);
    assign sw0Sel  = (aluOut[15:1] == 15'h7FFC);
    assign sw1Sel  = (aluOut[15:1] == 15'h7FFD);

    always_comb begin
        rdData = 16'd0;
        if (isLoad) begin
            if (ramSel) begin
                rdData = ram_q[aluOut[5:1]];
            end else if (dispSel) begin
                rdData = {9'd0, display_q};
            end else if (sw0Sel) begin
                rdData = {15'd0, io_sw0};
            end else if (sw1Sel) begin
                rdData = {15'd0, io_sw1};
            end
        end
    end

    assign wrData = isLoad ? rdData : aluOut;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q      <= 16'd0;
            display_q <= 7'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'd0;
            end
        end else begin
            pc_q <= pc_d;
            if (regWe && (wrIdx != 3'd7)) begin
                regs_q[wrIdx] <= wrData;
            end
            if (dWr && dispSel) begin
                display_q <= storeData[6:0];
            end
        end
    end

    // Data RAM keeps its contents across reset but never commits while reset is held.
    always_ff @(posedge clock) begin
        if (reset && dWr && ramSel) begin
            ram_q[aluOut[5:1]] <= storeData;
        end
    end

    assign io_display = display_q;
    assign iaddr      = pc_q;
    assign idata      = instr;
    assign draddr     = aluOut;
    assign dwdata     = storeData;
    assign drdata     = rdData;
    assign dwrite     = dWr;
    assign dread      = isLoad;
    assign alu_out    = aluOut;

endmodule

// File: tb/tb_leglite_single_system.sv
// Directed bench for leglite_single_system: default program loop, async reset,
// then injected instructions exercising the ISA and memory map.
module tb_leglite_single_system;

    logic        clock;
    logic        reset;
    logic        io_sw0;
    logic        io_sw1;
    logic [6:0]  io_display;
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic [15:0] draddr;
    logic [15:0] dwdata;
    logic [15:0] drdata;
    logic        dwrite;
    logic        dread;
    logic [15:0] alu_out;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [15:0] expPc;
    logic [15:0] forcedInstr;
    logic [15:0] holdPcs [0:3];

    leglite_single_system dut (
        .clock      (clock),
        .reset      (reset),
        .io_sw0     (io_sw0),
        .io_sw1     (io_sw1),
        .io_display (io_display),
        .iaddr      (iaddr),
        .idata      (idata),
        .draddr     (draddr),
        .dwdata     (dwdata),
        .drdata     (drdata),
        .dwrite     (dwrite),
        .dread      (dread),
        .alu_out    (alu_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Counts every comparison and reports any mismatch on one line.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] encR(input logic [2:0] funct, input logic [2:0] rd,
                                         input logic [2:0] rn, input logic [2:0] rm);
        return {4'h0, rm, rn, rd, funct};
    endfunction

    function automatic logic [15:0] encI(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rn, input int imm);
        logic [5:0] imm6;
        imm6 = imm[5:0];
        return {op, imm6, rn, rd};
    endfunction

    function automatic logic [15:0] encCbz(input logic [8:0] off9, input logic [2:0] rt);
        return {4'h5, off9, rt};
    endfunction

    // Injects one instruction at a negedge, checks the PC, and advances the expected PC.
    task automatic applyStimulus(input logic [15:0] ins, input logic [15:0] pcDelta);
        @(negedge clock);
        forcedInstr = ins;
        force dut.instr = forcedInstr;
        #1;
        checkOutput("iaddr", iaddr, expPc);
        expPc = expPc + pcDelta;
    endtask

    initial begin
        holdPcs[0] = 16'h0002;
        holdPcs[1] = 16'h0004;
        holdPcs[2] = 16'h0008;
        holdPcs[3] = 16'h000A;
        reset  = 1'b0;
        io_sw0 = 1'b0;
        io_sw1 = 1'b0;
        expPc  = 16'd0;
        forcedInstr = 16'hF000;

        #1;
        checkOutput("rstIaddr", iaddr, 16'h0000);
        checkOutput("rstIdata", idata, 16'h1039);
        checkOutput("rstDisplay", {9'd0, io_display}, 16'h0000);
        checkOutput("rstDwrite", {15'd0, dwrite}, 16'h0000);

        @(negedge clock);
        reset  = 1'b1;
        io_sw0 = 1'b1;

        // Count loop: i counts committed edges since reset released.
        for (int i = 0; i < 25; i++) begin
            #1;
            checkOutput("cntIaddr", iaddr, (i == 0) ? 16'd0 : 16'(((i - 1) % 5) * 2 + 2));
            checkOutput("cntDisplay", {9'd0, io_display}, (i < 5) ? 16'd0 : 16'(1 + (i - 5) / 5));
            if ((i % 5 == 1)) begin
                checkOutput("cntDread", {15'd0, dread}, 16'd1);
                checkOutput("cntLdAddr", draddr, 16'hFFF8);
                checkOutput("cntLdData", drdata, 16'd1);
            end
            if ((i % 5 == 2)) begin
                checkOutput("cntCbzAlu", alu_out, 16'd1);
            end
            if ((i % 5 == 4)) begin
                checkOutput("cntDwrite", {15'd0, dwrite}, 16'd1);
                checkOutput("cntStAddr", draddr, 16'hFFF0);
                checkOutput("cntStData", dwdata, 16'((i + 1) / 5));
            end
            @(negedge clock);
        end

        io_sw0 = 1'b0;
        #1;
        checkOutput("holdStartIaddr", iaddr, 16'h000A);
        checkOutput("holdStartDisp", {9'd0, io_display}, 16'd5);
        @(negedge clock);
        for (int i = 26; i < 34; i++) begin
            #1;
            checkOutput("holdIaddr", iaddr, holdPcs[(i - 26) % 4]);
            checkOutput("holdDisplay", {9'd0, io_display}, 16'd5);
            if ((i - 26) % 4 == 0) begin
                checkOutput("holdLdData", drdata, 16'd0);
            end
            if ((i - 26) % 4 == 1) begin
                checkOutput("holdCbzAlu", alu_out, 16'd0);
            end
            @(negedge clock);
        end

        // Asynchronous reset dropped between edges.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncIaddr", iaddr, 16'h0000);
        checkOutput("asyncDisplay", {9'd0, io_display}, 16'h0000);
        checkOutput("asyncIdata", idata, 16'h1039);
        @(posedge clock);
        #1;
        checkOutput("asyncHeldIaddr", iaddr, 16'h0000);
        reset  = 1'b1;
        io_sw1 = 1'b1;
        expPc  = 16'd0;

        // Build 0x1234 in X1: 9 doubled nine times, plus 52.
        applyStimulus(encI(4'd1, 3'd1, 3'd7, 9), 16'd2);
        repeat (9) applyStimulus(encR(3'd0, 3'd1, 3'd1, 3'd1), 16'd2);
        applyStimulus(encI(4'd1, 3'd1, 3'd1, 31), 16'd2);
        applyStimulus(encI(4'd1, 3'd1, 3'd1, 21), 16'd2);
        checkOutput("addiResult", alu_out, 16'h1234);

        applyStimulus(encI(4'd4, 3'd1, 3'd7, 16), 16'd2);
        checkOutput("stDwrite", {15'd0, dwrite}, 16'd1);
        checkOutput("stAddr", draddr, 16'h0010);
        checkOutput("stData", dwdata, 16'h1234);
        applyStimulus(encI(4'd4, 3'd1, 3'd7, 0), 16'd2);
        applyStimulus(encI(4'd3, 3'd3, 3'd7, 16), 16'd2);
        checkOutput("ldDread", {15'd0, dread}, 16'd1);
        checkOutput("ldRam", drdata, 16'h1234);
        applyStimulus(encI(4'd3, 3'd3, 3'd7, -6), 16'd2);
        checkOutput("ldSw1Addr", draddr, 16'hFFFA);
        checkOutput("ldSw1", drdata, 16'd1);

        applyStimulus(encI(4'd1, 3'd4, 3'd7, 1), 16'd2);
        repeat (8) applyStimulus(encR(3'd0, 3'd4, 3'd4, 3'd4), 16'd2);
        applyStimulus(encI(4'd3, 3'd3, 3'd4, 0), 16'd2);
        checkOutput("ldUnmapAddr", draddr, 16'h0100);
        checkOutput("ldUnmap", drdata, 16'h0000);

        applyStimulus(encI(4'd1, 3'd5, 3'd7, 5), 16'd2);
        applyStimulus(encI(4'd1, 3'd6, 3'd7, 7), 16'd2);
        applyStimulus(encR(3'd1, 3'd2, 3'd5, 3'd6), 16'd2);
        checkOutput("subAlu", alu_out, 16'hFFFE);
        applyStimulus(encI(4'd1, 3'd0, 3'd2, 0), 16'd2);
        checkOutput("subWriteback", alu_out, 16'hFFFE);
        applyStimulus(encR(3'd2, 3'd2, 3'd5, 3'd6), 16'd2);
        checkOutput("andAlu", alu_out, 16'h0005);
        applyStimulus(encR(3'd3, 3'd2, 3'd5, 3'd6), 16'd2);
        checkOutput("orrAlu", alu_out, 16'h0007);
        applyStimulus(encI(4'd2, 3'd2, 3'd1, 12), 16'd2);
        checkOutput("andiAlu", alu_out, 16'h0004);

        applyStimulus(encI(4'd1, 3'd7, 3'd7, 5), 16'd2);
        checkOutput("x7WriteAlu", alu_out, 16'h0005);
        applyStimulus(encI(4'd1, 3'd0, 3'd7, 0), 16'd2);
        checkOutput("x7ReadsZero", alu_out, 16'h0000);

        applyStimulus(encR(3'd4, 3'd1, 3'd5, 3'd6), 16'd2);
        checkOutput("funct4Dwrite", {15'd0, dwrite}, 16'd0);
        applyStimulus(encI(4'd1, 3'd0, 3'd1, 0), 16'd2);
        checkOutput("funct4NoWrite", alu_out, 16'h1234);

        applyStimulus(encI(4'd4, 3'd1, 3'd7, -16), 16'd2);
        checkOutput("stDispAddr", draddr, 16'hFFF0);
        applyStimulus(encI(4'd3, 3'd3, 3'd7, -16), 16'd2);
        checkOutput("dispValue", {9'd0, io_display}, 16'h0034);
        checkOutput("ldDisp", drdata, 16'h0034);

        applyStimulus(encCbz(9'd5, 3'd2), 16'd2);
        checkOutput("cbzNotTakenAlu", alu_out, 16'h0004);
        applyStimulus(encCbz(9'h1FD, 3'd7), 16'hFFFA);
        checkOutput("cbzTakenAlu", alu_out, 16'h0000);
        applyStimulus(16'h6800, 16'hF000);
        applyStimulus(16'h67FF, 16'h0FFE);
        applyStimulus(16'hF000, 16'd2);
        checkOutput("nopDwrite", {15'd0, dwrite}, 16'd0);
        applyStimulus(16'hF000, 16'd2);

        release dut.instr;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
